// File: rtl/cell_sweep_pkg.sv
// cell_sweep_pkg: shared widths, FSM state encoding and MISR step function for cell_sweeper.
// Rev 1.0
`default_nettype none

package cell_sweep_pkg;

  localparam int PAGE_W = 4;
  localparam int IN_W   = 6;
  localparam int OUT_W  = 8;
  localparam int SIG_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Shift left with polynomial feedback, then fold the sampled byte into the low bits.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] poly,
                                                 input logic [OUT_W-1:0] data);
    return {sig[SIG_W-2:0], 1'b0}
         ^ (sig[SIG_W-1] ? poly : {SIG_W{1'b0}})
         ^ {{(SIG_W-OUT_W){1'b0}}, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cell_sweep_misr.sv
// cell_sweep_misr: 16-bit MISR with seed load and enable, compressing one byte per enabled cycle.
// Rev 1.0
`default_nettype none

module cell_sweep_misr
  import cell_sweep_pkg::*;
#(
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
  parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [OUT_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_step(sig, POLY, data);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cell_sweeper.sv
// cell_sweeper: walks pages x 64 input vectors on cell_mux, compressing sampled outputs into a MISR.
// Optional CELL_SWEEP_STREAM_EN adds a valid/ready port emitting each sampled {input, output} pair.
// Rev 1.0
`default_nettype none

module cell_sweeper
  import cell_sweep_pkg::*;
#(
  parameter int unsigned      PAGE_FIRST    = 0,
  parameter int unsigned      PAGE_LAST     = 15,
  parameter int unsigned      SETTLE_CYCLES = 2,
  parameter logic [SIG_W-1:0] SIG_SEED      = 16'hFFFF,
  parameter logic [SIG_W-1:0] SIG_POLY      = 16'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [PAGE_W-1:0] page_o,
  output logic [IN_W-1:0]   in_o,
  input  logic [OUT_W-1:0]  out_i,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature
`ifdef CELL_SWEEP_STREAM_EN
  ,
  output logic              st_valid,
  output logic [13:0]       st_data,
  input  logic              st_ready
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PAGE_W-1:0] PG_FIRST = PAGE_W'(PAGE_FIRST);
  localparam logic [PAGE_W-1:0] PG_LAST  = PAGE_W'(PAGE_LAST);

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             last_vec;
  logic             misr_load;
  logic             misr_en;

  assign last_vec  = (page_o == PG_LAST) && (in_o == '1);
  assign misr_load = (state == IDLE) && start && !abort;
  assign misr_en   = (state == SAMPLE) && !abort;

`ifdef CELL_SWEEP_STREAM_EN
  logic last_pending;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      page_o     <= '0;
      in_o       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
`ifdef CELL_SWEEP_STREAM_EN
      st_valid     <= 1'b0;
      st_data      <= '0;
      last_pending <= 1'b0;
`endif
    end else if (abort && (state != IDLE)) begin
      state      <= IDLE;
      page_o     <= '0;
      in_o       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
`ifdef CELL_SWEEP_STREAM_EN
      st_valid   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= DRIVE;
            busy       <= 1'b1;
            page_o     <= PG_FIRST;
            in_o       <= '0;
            settle_cnt <= '0;
          end
        end
        DRIVE: begin
          if (settle_cnt == CNT_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          // The vector just sampled is consumed here; in_o wraps into the next page.
          if (last_vec) begin
            page_o <= '0;
            in_o   <= '0;
          end else begin
            in_o <= in_o + 1'b1;
            if (in_o == '1) page_o <= page_o + 1'b1;
          end
`ifdef CELL_SWEEP_STREAM_EN
          st_valid     <= 1'b1;
          st_data      <= {in_o, out_i};
          last_pending <= last_vec;
          state        <= EMIT;
`else
          if (last_vec) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= DRIVE;
          end
`endif
        end
`ifdef CELL_SWEEP_STREAM_EN
        EMIT: begin
          if (st_ready) begin
            st_valid <= 1'b0;
            if (last_pending) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRIVE;
            end
          end
        end
`endif
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  cell_sweep_misr #(
    .SEED (SIG_SEED),
    .POLY (SIG_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (misr_load),
    .en    (misr_en),
    .data  (out_i),
    .sig   (signature)
  );

endmodule

`default_nettype wire

// File: tb/tb_cell_sweeper.sv
// tb_cell_sweeper: scoreboard bench for cell_sweeper with a one-page and a full-range instance.
`default_nettype none

module tb_cell_sweeper;

  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, abort_a, busy_a, done_a;
  logic [3:0]  page_a;
  logic [5:0]  in_a;
  logic [7:0]  out_a;
  logic [15:0] sig_a;
  logic        st_valid_a, st_ready_a;
  logic [13:0] st_data_a;

  logic        start_b, abort_b, busy_b, done_b;
  logic [3:0]  page_b;
  logic [5:0]  in_b;
  logic [7:0]  out_b;
  logic [15:0] sig_b;
  logic        st_valid_b, st_ready_b;
  logic [13:0] st_data_b;

  assign out_a = {2'b00, in_a} ^ {4'h0, page_a};
  assign out_b = {2'b00, in_b} ^ {4'h0, page_b};
  assign st_ready_b = 1'b1;

  cell_sweeper #(.PAGE_FIRST(0), .PAGE_LAST(0), .SETTLE_CYCLES(SETTLE)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .page_o(page_a), .in_o(in_a), .out_i(out_a),
    .busy(busy_a), .done(done_a), .signature(sig_a)
`ifdef CELL_SWEEP_STREAM_EN
    , .st_valid(st_valid_a), .st_data(st_data_a), .st_ready(st_ready_a)
`endif
  );

  cell_sweeper #(.PAGE_FIRST(0), .PAGE_LAST(15), .SETTLE_CYCLES(SETTLE)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .page_o(page_b), .in_o(in_b), .out_i(out_b),
    .busy(busy_b), .done(done_b), .signature(sig_b)
`ifdef CELL_SWEEP_STREAM_EN
    , .st_valid(st_valid_b), .st_data(st_data_b), .st_ready(st_ready_b)
`endif
  );

`ifndef CELL_SWEEP_STREAM_EN
  assign st_valid_a = 1'b0;
  assign st_data_a  = '0;
  assign st_valid_b = 1'b0;
  assign st_data_b  = '0;
  initial st_ready_a = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_sig(input int pf, input int pl);
    logic [15:0] s = 16'hFFFF;
    logic [7:0]  d;
    for (int p = pf; p <= pl; p++) begin
      for (int v = 0; v < 64; v++) begin
        d = 8'(v ^ p);
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, d};
      end
    end
    return s;
  endfunction

  typedef struct {
    logic [15:0] sig;
    int          nvec;
  } exp_t;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [13:0] beat_q[$];
  exp_t        e_a, e_b;

  int   bc_a = 0, emit_a = 0, done_cnt_a = 0;
  int   bc_b = 0, emit_b = 0, done_cnt_b = 0;
  logic pbusy_a = 1'b0, pbusy_b = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bc_a = 0; emit_a = 0; pbusy_a = 1'b0;
    end else begin
      if (busy_a && !pbusy_a) begin bc_a = 0; emit_a = 0; end
      if (busy_a) bc_a++;
      if (st_valid_a) emit_a++;
      if (done_a) begin
        done_cnt_a++;
        check("done_after_busy_a", 32'(pbusy_a), 32'd1);
        check("zero_vec_at_done_a", {page_a, in_a, busy_a}, 32'd0);
        if (exp_a.size() == 0) begin
          check("unexpected_done_a", 32'd1, 32'd0);
        end else begin
          e_a = exp_a.pop_front();
          check("signature_a", sig_a, e_a.sig);
          check("busy_len_a", bc_a, e_a.nvec * (SETTLE + 1) + emit_a);
        end
      end
      pbusy_a = busy_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bc_b = 0; emit_b = 0; pbusy_b = 1'b0;
    end else begin
      if (busy_b && !pbusy_b) begin bc_b = 0; emit_b = 0; end
      if (busy_b) bc_b++;
      if (st_valid_b) emit_b++;
`ifndef CELL_SWEEP_STREAM_EN
      // {page, in} is exactly the vector index for a sweep starting at page 0.
      if (busy_b) check("position_b", {page_b, in_b}, (bc_b - 1) / (SETTLE + 1));
`endif
      if (done_b) begin
        done_cnt_b++;
        check("done_after_busy_b", 32'(pbusy_b), 32'd1);
        check("zero_vec_at_done_b", {page_b, in_b, busy_b}, 32'd0);
        if (exp_b.size() == 0) begin
          check("unexpected_done_b", 32'd1, 32'd0);
        end else begin
          e_b = exp_b.pop_front();
          check("signature_b", sig_b, e_b.sig);
          check("busy_len_b", bc_b, e_b.nvec * (SETTLE + 1) + emit_b);
        end
      end
      pbusy_b = busy_b;
    end
  end

`ifdef CELL_SWEEP_STREAM_EN
  int          stall_left = 0;
  bit          stalled_once = 0;
  bit          prev_valid = 0, prev_hs = 0;
  logic [13:0] prev_data = '0;
  logic [13:0] beat_exp;
  logic        rdy;
  initial st_ready_a = 1'b0;

  always @(negedge clk) begin
    if (st_valid_a && st_data_a[13:8] == 6'd5 && !stalled_once) begin
      stall_left   = 50;
      stalled_once = 1;
    end
    if (stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end else begin
      rdy = 1'($urandom_range(0, 1));
    end
    if (prev_valid && !prev_hs && st_valid_a) check("st_data_stable", st_data_a, prev_data);
    st_ready_a = rdy;
    if (st_valid_a && rdy) begin
      if (beat_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_exp = beat_q.pop_front();
        check("beat_a", st_data_a, beat_exp);
      end
    end
    prev_valid = st_valid_a;
    prev_hs    = st_valid_a && rdy;
    prev_data  = st_data_a;
  end
`endif

  task automatic wait_done_a(input int target, input int limit);
    for (int i = 0; i < limit && done_cnt_a < target; i++) @(negedge clk);
    check("done_seen_a", done_cnt_a, target);
  endtask

  task automatic wait_done_b(input int target, input int limit);
    for (int i = 0; i < limit && done_cnt_b < target; i++) @(negedge clk);
    check("done_seen_b", done_cnt_b, target);
  endtask

  initial begin
    logic [5:0] vv;
    bit         found;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    repeat (3) @(negedge clk);
    check("in_reset_a", {page_a, in_a, busy_a, done_a, sig_a}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_a", {page_a, in_a, busy_a, done_a, sig_a}, 32'd0);
      check("idle_b", {page_b, in_b, busy_b, done_b, sig_b}, 32'd0);
    end

    // One-page sweep, with a stray start mid-sweep that must be ignored.
    start_a = 1'b1;
    exp_a.push_back('{model_sig(0, 0), 64});
    for (int v = 0; v < 64; v++) begin
      vv = 6'(v);
      beat_q.push_back({vv, 2'b00, vv});
    end
    @(negedge clk);
    start_a = 1'b0;
    check("start_busy_a", 32'(busy_a), 32'd1);
    check("start_vec_a", {page_a, in_a}, 32'd0);
    check("start_seed_a", sig_a, 32'hFFFF);
    repeat (50) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(1, 2000);

    // start and abort together in IDLE: nothing starts.
    @(negedge clk);
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("start_abort_idle_a", {busy_a, done_a}, 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset mid-sweep.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_b", {page_b, in_b, busy_b, sig_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 16-page sweep.
    start_b = 1'b1;
    exp_b.push_back('{model_sig(0, 15), 1024});
    @(negedge clk);
    start_b = 1'b0;
    wait_done_b(1, 6000);

    // Abort at vector 10 of page 3.
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (page_b == 4'd3 && in_b == 6'd10) found = 1;
      else @(negedge clk);
    end
    check("abort_point_reached", 32'(found), 32'd1);
    abort_b = 1'b1;
    @(negedge clk);
    abort_b = 1'b0;
    check("abort_b", {page_b, in_b, busy_b, done_b}, 32'd0);
    repeat (10) @(negedge clk);
    check("no_done_after_abort", done_cnt_b, 32'd1);

    // Restart after abort reproduces the clean signature.
    start_b = 1'b1;
    exp_b.push_back('{model_sig(0, 15), 1024});
    @(negedge clk);
    start_b = 1'b0;
    wait_done_b(2, 6000);

    repeat (5) @(negedge clk);
    check("done_count_a", done_cnt_a, 32'd1);
    check("done_count_b", done_cnt_b, 32'd2);
    check("exp_a_drained", exp_a.size(), 32'd0);
    check("exp_b_drained", exp_b.size(), 32'd0);
`ifdef CELL_SWEEP_STREAM_EN
    check("beats_drained", beat_q.size(), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
